// File: rtl/ula_ctrl_seq.sv
// ula_ctrl_seq: ALU control and execute unit for the multicycle MIPS datapath.
// Decodes ALUOp/func into a 4-bit operation code and executes it behind a
// start/done handshake. Single-cycle ops complete in one cycle; MULT/MULTU
// run as WIDTH-step shift-add and DIV/DIVU as WIDTH-step restoring division
// into internal HI/LO registers, which MFHI/MFLO read back.
//
// Ports:
//   clk_i      system clock, rising edge
//   reset_i    synchronous active-high reset
//   start_i    request, accepted only while busy_o = 0
//   ALUOp_i    00 add, 01 sub, 10 R-type (decode func_i), 11 invalid
//   func_i     R-type function field, sampled with start_i
//   a_i, b_i   operands (rs, rt), sampled with start_i
//   OP_o       operation code of the last completed request
//   result_o   registered result
//   zero_o     result_o == 0
//   busy_o     multiply/divide in progress
//   done_o     one-cycle completion pulse
//   invalid_o  last completed request was undefined
module ula_ctrl_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             start_i,
    input  logic [1:0]       ALUOp_i,
    input  logic [5:0]       func_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [3:0]       OP_o,
    output logic [WIDTH-1:0] result_o,
    output logic             zero_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             invalid_o
);

    localparam int CW = $clog2(WIDTH);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_DIV  = 2'd2;

    localparam logic [3:0] OP_AND   = 4'b0000;
    localparam logic [3:0] OP_OR    = 4'b0001;
    localparam logic [3:0] OP_ADD   = 4'b0010;
    localparam logic [3:0] OP_MFLO  = 4'b0011;
    localparam logic [3:0] OP_SUB   = 4'b0110;
    localparam logic [3:0] OP_SLT   = 4'b0111;
    localparam logic [3:0] OP_SLTU  = 4'b1000;
    localparam logic [3:0] OP_MULT  = 4'b1001;
    localparam logic [3:0] OP_MULTU = 4'b1010;
    localparam logic [3:0] OP_DIV   = 4'b1011;
    localparam logic [3:0] OP_NOR   = 4'b1100;
    localparam logic [3:0] OP_DIVU  = 4'b1101;
    localparam logic [3:0] OP_MFHI  = 4'b1110;
    localparam logic [3:0] OP_INV   = 4'b1111;

    logic [1:0]         state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    // Working register: {partial product, multiplier} or {remainder, quotient}
    logic [2*WIDTH-1:0] wk_q, wk_d;
    // Multiplicand magnitude or divisor magnitude
    logic [WIDTH-1:0]   dv_q, dv_d;
    logic               neg_q, neg_d;     // negate product / quotient at the end
    logic               rneg_q, rneg_d;   // negate remainder (dividend sign)
    logic               dbz_q, dbz_d;     // divide by zero
    logic [WIDTH-1:0]   a0_q, a0_d;       // original dividend, HI on divide by zero
    logic [3:0]         pop_q, pop_d;     // op code of the in-flight mul/div
    logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic [3:0]         op_q, op_d;
    logic               done_q, done_d;
    logic               inv_q, inv_d;

    // ---------------- decode ----------------
    logic [3:0] op_dec;
    always_comb begin
        op_dec = OP_INV;
        case (ALUOp_i)
            2'b00: op_dec = OP_ADD;
            2'b01: op_dec = OP_SUB;
            2'b10: begin
                case (func_i)
                    6'b100000: op_dec = OP_ADD;
                    6'b100010: op_dec = OP_SUB;
                    6'b100100: op_dec = OP_AND;
                    6'b100101: op_dec = OP_OR;
                    6'b100111: op_dec = OP_NOR;
                    6'b101010: op_dec = OP_SLT;
                    6'b101011: op_dec = OP_SLTU;
                    6'b011000: op_dec = OP_MULT;
                    6'b011001: op_dec = OP_MULTU;
                    6'b011010: op_dec = OP_DIV;
                    6'b011011: op_dec = OP_DIVU;
                    6'b010000: op_dec = OP_MFHI;
                    6'b010010: op_dec = OP_MFLO;
                    default:   op_dec = OP_INV;
                endcase
            end
            default: op_dec = OP_INV;
        endcase
    end

    logic is_mul, is_div, is_sgn;
    assign is_mul = (op_dec == OP_MULT) || (op_dec == OP_MULTU);
    assign is_div = (op_dec == OP_DIV)  || (op_dec == OP_DIVU);
    assign is_sgn = (op_dec == OP_MULT) || (op_dec == OP_DIV);

    // Operand signs and magnitudes; unsigned ops see sign = 0.
    logic             sgn_a, sgn_b;
    logic [WIDTH-1:0] mag_a, mag_b;
    assign sgn_a = is_sgn & a_i[WIDTH-1];
    assign sgn_b = is_sgn & b_i[WIDTH-1];
    assign mag_a = sgn_a ? -a_i : a_i;
    assign mag_b = sgn_b ? -b_i : b_i;

    // ---------------- single-cycle datapath ----------------
    logic [WIDTH-1:0] sc_res;
    always_comb begin
        sc_res = '0;
        case (op_dec)
            OP_ADD:  sc_res = a_i + b_i;
            OP_SUB:  sc_res = a_i - b_i;
            OP_AND:  sc_res = a_i & b_i;
            OP_OR:   sc_res = a_i | b_i;
            OP_NOR:  sc_res = ~(a_i | b_i);
            OP_SLT:  sc_res = {{(WIDTH-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
            OP_SLTU: sc_res = {{(WIDTH-1){1'b0}}, (a_i < b_i)};
            OP_MFHI: sc_res = hi_q;
            OP_MFLO: sc_res = lo_q;
            default: sc_res = '0;
        endcase
    end

    // ---------------- iteration steps ----------------
    // Shift-add: add multiplicand into the upper half when the multiplier LSB
    // is set, then shift the whole register right with the carry.
    logic [WIDTH:0]     msum;
    logic [2*WIDTH-1:0] mul_nxt, mul_fin;
    assign msum    = {1'b0, wk_q[2*WIDTH-1:WIDTH]} + (wk_q[0] ? {1'b0, dv_q} : '0);
    assign mul_nxt = {msum, wk_q[WIDTH-1:1]};
    assign mul_fin = neg_q ? -mul_nxt : mul_nxt;

    // Restoring divide: shift the next dividend bit into the remainder, subtract
    // the divisor if it fits and shift the outcome into the quotient.
    logic [WIDTH:0]     rsh;
    logic [WIDTH-1:0]   dsub;
    logic               ge;
    logic [2*WIDTH-1:0] div_nxt;
    logic [WIDTH-1:0]   quo, rem;
    assign rsh     = {wk_q[2*WIDTH-1:WIDTH], wk_q[WIDTH-1]};
    assign dsub    = rsh[WIDTH-1:0] - dv_q;
    assign ge      = rsh >= {1'b0, dv_q};
    assign div_nxt = {(ge ? dsub : rsh[WIDTH-1:0]), wk_q[WIDTH-2:0], ge};
    assign quo     = neg_q  ? -div_nxt[WIDTH-1:0]       : div_nxt[WIDTH-1:0];
    assign rem     = rneg_q ? -div_nxt[2*WIDTH-1:WIDTH] : div_nxt[2*WIDTH-1:WIDTH];

    logic last;
    assign last = (cnt_q == CW'(WIDTH-1));

    // ---------------- next state ----------------
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        wk_d     = wk_q;
        dv_d     = dv_q;
        neg_d    = neg_q;
        rneg_d   = rneg_q;
        dbz_d    = dbz_q;
        a0_d     = a0_q;
        pop_d    = pop_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        result_d = result_q;
        op_d     = op_q;
        inv_d    = inv_q;
        done_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    if (is_mul) begin
                        state_d = S_MUL;
                        cnt_d   = '0;
                        wk_d    = {{WIDTH{1'b0}}, mag_b};
                        dv_d    = mag_a;
                        neg_d   = sgn_a ^ sgn_b;
                        pop_d   = op_dec;
                    end else if (is_div) begin
                        state_d = S_DIV;
                        cnt_d   = '0;
                        wk_d    = {{WIDTH{1'b0}}, mag_a};
                        dv_d    = mag_b;
                        neg_d   = sgn_a ^ sgn_b;
                        rneg_d  = sgn_a;
                        dbz_d   = (b_i == '0);
                        a0_d    = a_i;
                        pop_d   = op_dec;
                    end else begin
                        result_d = sc_res;
                        op_d     = op_dec;
                        inv_d    = (op_dec == OP_INV);
                        done_d   = 1'b1;
                    end
                end
            end
            S_MUL: begin
                wk_d = mul_nxt;
                if (last) begin
                    state_d  = S_IDLE;
                    hi_d     = mul_fin[2*WIDTH-1:WIDTH];
                    lo_d     = mul_fin[WIDTH-1:0];
                    result_d = mul_fin[WIDTH-1:0];
                    op_d     = pop_q;
                    inv_d    = 1'b0;
                    done_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DIV: begin
                wk_d = div_nxt;
                if (last) begin
                    state_d  = S_IDLE;
                    // Divide by zero still runs the full sequence; only the
                    // committed values are overridden.
                    hi_d     = dbz_q ? a0_q : rem;
                    lo_d     = dbz_q ? {WIDTH{1'b1}} : quo;
                    result_d = dbz_q ? {WIDTH{1'b1}} : quo;
                    op_d     = pop_q;
                    inv_d    = 1'b0;
                    done_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            wk_q     <= '0;
            dv_q     <= '0;
            neg_q    <= 1'b0;
            rneg_q   <= 1'b0;
            dbz_q    <= 1'b0;
            a0_q     <= '0;
            pop_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            result_q <= '0;
            op_q     <= '0;
            done_q   <= 1'b0;
            inv_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            wk_q     <= wk_d;
            dv_q     <= dv_d;
            neg_q    <= neg_d;
            rneg_q   <= rneg_d;
            dbz_q    <= dbz_d;
            a0_q     <= a0_d;
            pop_q    <= pop_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            result_q <= result_d;
            op_q     <= op_d;
            done_q   <= done_d;
            inv_q    <= inv_d;
        end
    end

    assign OP_o      = op_q;
    assign result_o  = result_q;
    assign zero_o    = (result_q == '0);
    assign busy_o    = (state_q != S_IDLE);
    assign done_o    = done_q;
    assign invalid_o = inv_q;

endmodule

// File: tb/tb_ula_ctrl_seq.sv
module tb_ula_ctrl_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        sel8 = 1'b0;
    logic [1:0]  ALUOp = 2'b00;
    logic [5:0]  func = 6'd0;
    logic [31:0] a = '0, b = '0;

    logic [3:0]  op32, op8;
    logic [31:0] res32;
    logic [7:0]  res8;
    logic        zero32, busy32, done32, inv32;
    logic        zero8, busy8, done8, inv8;
    logic        start32_w, start8_w;

    int total = 0;
    int bad   = 0;

    logic [63:0] m_hi [2];
    logic [63:0] m_lo [2];

    always #5 clk = ~clk;

    assign start32_w = start & ~sel8;
    assign start8_w  = start & sel8;

    ula_ctrl_seq #(.WIDTH(32)) dut32 (
        .clk_i(clk), .reset_i(rst), .start_i(start32_w), .ALUOp_i(ALUOp), .func_i(func),
        .a_i(a), .b_i(b), .OP_o(op32), .result_o(res32), .zero_o(zero32),
        .busy_o(busy32), .done_o(done32), .invalid_o(inv32));

    ula_ctrl_seq #(.WIDTH(8)) dut8 (
        .clk_i(clk), .reset_i(rst), .start_i(start8_w), .ALUOp_i(ALUOp), .func_i(func),
        .a_i(a[7:0]), .b_i(b[7:0]), .OP_o(op8), .result_o(res8), .zero_o(zero8),
        .busy_o(busy8), .done_o(done8), .invalid_o(inv8));

    // Observed outputs of whichever instance is selected.
    logic [31:0] r_res;
    logic [3:0]  r_op;
    logic        r_zero, r_busy, r_done, r_inv;
    assign r_res  = sel8 ? {24'd0, res8} : res32;
    assign r_op   = sel8 ? op8 : op32;
    assign r_zero = sel8 ? zero8 : zero32;
    assign r_busy = sel8 ? busy8 : busy32;
    assign r_done = sel8 ? done8 : done32;
    assign r_inv  = sel8 ? inv8 : inv32;

    // Behavioural reference: op-code table plus plain integer arithmetic.
    function automatic void model(input int w, input logic [1:0] op2, input logic [5:0] f,
                                  input logic [63:0] ai, input logic [63:0] bi,
                                  inout logic [63:0] hi, inout logic [63:0] lo,
                                  output logic [3:0] opc, output logic [63:0] res,
                                  output bit inv, output bit multi);
        logic [63:0] mask, p;
        longint t, sa, sb, q, r;
        mask = (64'd1 << w) - 64'd1;
        ai = ai & mask;
        bi = bi & mask;
        t  = longint'(ai << (64 - w)); sa = t >>> (64 - w);
        t  = longint'(bi << (64 - w)); sb = t >>> (64 - w);
        inv = 0; multi = 0; res = 0;
        opc = 4'b1111;
        if (op2 == 2'b00) opc = 4'b0010;
        else if (op2 == 2'b01) opc = 4'b0110;
        else if (op2 == 2'b10) begin
            case (f)
                6'b100000: opc = 4'b0010;
                6'b100010: opc = 4'b0110;
                6'b100100: opc = 4'b0000;
                6'b100101: opc = 4'b0001;
                6'b100111: opc = 4'b1100;
                6'b101010: opc = 4'b0111;
                6'b101011: opc = 4'b1000;
                6'b011000: opc = 4'b1001;
                6'b011001: opc = 4'b1010;
                6'b011010: opc = 4'b1011;
                6'b011011: opc = 4'b1101;
                6'b010000: opc = 4'b1110;
                6'b010010: opc = 4'b0011;
                default:   opc = 4'b1111;
            endcase
        end
        case (opc)
            4'b0010: res = (ai + bi) & mask;
            4'b0110: res = (ai - bi) & mask;
            4'b0000: res = ai & bi;
            4'b0001: res = ai | bi;
            4'b1100: res = ~(ai | bi) & mask;
            4'b0111: res = (sa < sb) ? 64'd1 : 64'd0;
            4'b1000: res = (ai < bi) ? 64'd1 : 64'd0;
            4'b1110: res = hi;
            4'b0011: res = lo;
            4'b1001, 4'b1010: begin
                multi = 1;
                p = (opc == 4'b1001) ? 64'(sa * sb) : ai * bi;
                hi = (p >> w) & mask;
                lo = p & mask;
                res = lo;
            end
            4'b1011, 4'b1101: begin
                multi = 1;
                if (bi == 0) begin
                    lo = mask; hi = ai;
                end else if (opc == 4'b1011) begin
                    q = sa / sb; r = sa % sb;
                    lo = 64'(q) & mask; hi = 64'(r) & mask;
                end else begin
                    lo = ai / bi; hi = ai % bi;
                end
                res = lo;
            end
            default: begin res = 0; inv = 1; end
        endcase
    endfunction

    // Issue one request to the selected instance and check its completion.
    task automatic do_op(input logic [1:0] op2, input logic [5:0] f,
                         input logic [31:0] ai, input logic [31:0] bi, input string nm);
        int w, lat, exp_lat;
        logic [3:0] eop;
        logic [63:0] eres;
        bit einv, multi;
        w = sel8 ? 8 : 32;
        model(w, op2, f, {32'd0, ai}, {32'd0, bi}, m_hi[sel8], m_lo[sel8], eop, eres, einv, multi);
        exp_lat = multi ? w + 1 : 1;
        ALUOp = op2; func = f; a = ai; b = bi; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 1;
        if (multi) begin
            total++;
            if (r_busy !== 1'b1) begin bad++; $display("FAIL %s busy got=%b exp=1", nm, r_busy); end
        end
        while (r_done !== 1'b1 && lat < w + 4) begin
            @(posedge clk); #1;
            lat++;
        end
        total++;
        if (lat != exp_lat) begin bad++; $display("FAIL %s latency got=%0d exp=%0d", nm, lat, exp_lat); end
        total++;
        if (r_res !== eres[31:0]) begin bad++; $display("FAIL %s result got=%h exp=%h", nm, r_res, eres[31:0]); end
        total++;
        if (r_op !== eop) begin bad++; $display("FAIL %s OP got=%b exp=%b", nm, r_op, eop); end
        total++;
        if (r_inv !== einv) begin bad++; $display("FAIL %s invalid got=%b exp=%b", nm, r_inv, einv); end
        total++;
        if (r_zero !== (eres == 0)) begin bad++; $display("FAIL %s zero got=%b exp=%b", nm, r_zero, (eres == 0)); end
        total++;
        if (r_busy !== 1'b0) begin bad++; $display("FAIL %s busy_at_done got=%b exp=0", nm, r_busy); end
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        m_hi[0] = 0; m_lo[0] = 0; m_hi[1] = 0; m_lo[1] = 0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        m_hi[0] = 0; m_lo[0] = 0; m_hi[1] = 0; m_lo[1] = 0;
        total++;
        if ({res32, op32, busy32, done32, inv32, zero32} !== {32'd0, 4'd0, 4'b0001}) begin
            bad++; $display("FAIL reset32 got=%h/%b/%b%b%b%b exp=0/0000/0001",
                            res32, op32, busy32, done32, inv32, zero32);
        end
        total++;
        if ({res8, op8, busy8, done8, inv8, zero8} !== {8'd0, 4'd0, 4'b0001}) begin
            bad++; $display("FAIL reset8 got=%h/%b/%b%b%b%b exp=0/0000/0001",
                            res8, op8, busy8, done8, inv8, zero8);
        end
    endtask

    task automatic test_single();
        sel8 = 1'b0;
        do_op(2'b10, 6'b100000, 32'd5, 32'd7, "add_5_7");
        do_op(2'b10, 6'b100010, 32'd7, 32'd7, "sub_7_7");
        do_op(2'b10, 6'b101010, 32'hFFFF_FFFF, 32'd1, "slt_neg");
        do_op(2'b10, 6'b101011, 32'hFFFF_FFFF, 32'd1, "sltu_big");
        do_op(2'b11, 6'b100000, 32'd3, 32'd4, "aluop11");
        do_op(2'b00, 6'b000000, 32'hFFFF_FFFF, 32'd2, "lw_add_wrap");
        do_op(2'b01, 6'b000000, 32'd0, 32'd1, "beq_sub_wrap");
        do_op(2'b10, 6'b111111, 32'd1, 32'd1, "bad_func");
        do_op(2'b10, 6'b100111, 32'h0F0F_0000, 32'h0000_00F0, "nor");
    endtask

    task automatic test_muldiv();
        sel8 = 1'b0;
        do_op(2'b10, 6'b011000, -32'sd3, 32'd7, "mult_m3_7");
        do_op(2'b10, 6'b010000, 32'd0, 32'd0, "mfhi_mult");
        do_op(2'b10, 6'b010010, 32'd0, 32'd0, "mflo_mult");
        do_op(2'b10, 6'b011001, 32'hFFFF_FFFF, 32'd2, "multu");
        do_op(2'b10, 6'b010000, 32'd0, 32'd0, "mfhi_multu");
        do_op(2'b10, 6'b011010, -32'sd7, 32'd2, "div_m7_2");
        do_op(2'b10, 6'b010000, 32'd0, 32'd0, "mfhi_div");
        do_op(2'b10, 6'b011011, 32'd9, 32'd0, "divu_by0");
        do_op(2'b10, 6'b010000, 32'd0, 32'd0, "mfhi_div0");
        do_op(2'b10, 6'b011010, 32'h8000_0000, 32'hFFFF_FFFF, "div_minneg");
        do_op(2'b10, 6'b011010, -32'sd5, 32'd0, "div_neg_by0");
        do_op(2'b10, 6'b010000, 32'd0, 32'd0, "mfhi_neg_div0");
    endtask

    task automatic test_busy_ignore();
        int ndone;
        logic [31:0] got;
        logic [3:0] eop;
        logic [63:0] eres;
        bit einv, multi;
        sel8 = 1'b0;
        model(32, 2'b10, 6'b011000, 64'h1234_5678, 64'hFFFF_FF00, m_hi[0], m_lo[0], eop, eres, einv, multi);
        ALUOp = 2'b10; func = 6'b011000; a = 32'h1234_5678; b = 32'hFFFF_FF00; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        ndone = 0; got = '0;
        for (int i = 0; i < 40; i++) begin
            if (i == 3 || i == 20) begin
                ALUOp = 2'b00; a = 32'd1; b = 32'd1; start = 1'b1;
            end else begin
                start = 1'b0;
            end
            if (done32) begin ndone++; got = res32; end
            @(posedge clk); #1;
        end
        start = 1'b0;
        total++;
        if (ndone != 1) begin bad++; $display("FAIL busy_ignore done_count got=%0d exp=1", ndone); end
        total++;
        if (got !== eres[31:0]) begin bad++; $display("FAIL busy_ignore result got=%h exp=%h", got, eres[31:0]); end
        do_op(2'b10, 6'b010000, 32'd0, 32'd0, "mfhi_after_ignore");
        do_op(2'b10, 6'b010010, 32'd0, 32'd0, "mflo_after_ignore");
    endtask

    task automatic test_reset_abort();
        int ndone;
        sel8 = 1'b0;
        ALUOp = 2'b10; func = 6'b011000; a = 32'h8765_4321; b = 32'h0000_0ABC; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        total++;
        if (busy32 !== 1'b1) begin bad++; $display("FAIL abort busy_before got=%b exp=1", busy32); end
        pulse_reset();
        ndone = 0;
        for (int i = 0; i < 40; i++) begin
            if (done32) ndone++;
            @(posedge clk); #1;
        end
        total++;
        if (ndone != 0) begin bad++; $display("FAIL abort done_count got=%0d exp=0", ndone); end
        do_op(2'b10, 6'b010000, 32'd0, 32'd0, "mfhi_after_abort");
        do_op(2'b10, 6'b010010, 32'd0, 32'd0, "mflo_after_abort");
    endtask

    task automatic test_width8();
        sel8 = 1'b1;
        do_op(2'b10, 6'b011001, 32'hFF, 32'hFF, "w8_multu_ff");
        do_op(2'b10, 6'b010000, 32'd0, 32'd0, "w8_mfhi");
        do_op(2'b10, 6'b010010, 32'd0, 32'd0, "w8_mflo");
        do_op(2'b10, 6'b011010, 32'h80, 32'hFF, "w8_div_minneg");
        do_op(2'b10, 6'b011010, 32'hF9, 32'h02, "w8_div_m7_2");
        do_op(2'b10, 6'b010000, 32'd0, 32'd0, "w8_mfhi_div");
        sel8 = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [7:0] ea;
        sel8 = 1'b1;
        ALUOp = 2'b10; func = 6'b100000;
        start = 1'b1;
        for (int i = 0; i < 6; i++) begin
            a = $urandom; b = $urandom;
            ea = a[7:0] + b[7:0];
            @(posedge clk); #1;
            total++;
            if (done8 !== 1'b1 || res8 !== ea) begin
                bad++; $display("FAIL b2b_add%0d done/result got=%b/%h exp=1/%h", i, done8, res8, ea);
            end
        end
        start = 1'b0;
        @(posedge clk); #1;
        total++;
        if (done8 !== 1'b0) begin bad++; $display("FAIL b2b_tail done got=%b exp=0", done8); end
        sel8 = 1'b0;
    endtask

    function automatic logic [31:0] pick(input int w);
        logic [31:0] v;
        case ($urandom_range(0, 5))
            0: v = 0;
            1: v = 32'hFFFF_FFFF;
            2: v = 32'd1 << (w - 1);
            3: v = 1;
            default: v = $urandom;
        endcase
        if (w < 32) v = v & ((32'd1 << w) - 1);
        return v;
    endfunction

    task automatic test_random();
        logic [5:0] fl [13];
        logic [1:0] op2;
        logic [5:0] f;
        fl = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b100111, 6'b101010, 6'b101011,
               6'b011000, 6'b011001, 6'b011010, 6'b011011, 6'b010000, 6'b010010};
        for (int i = 0; i < 120; i++) begin
            sel8 = (i % 3 == 0);
            op2 = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 3) != 0) op2 = 2'b10;
            f = ($urandom_range(0, 9) == 0) ? 6'($urandom) : fl[$urandom_range(0, 12)];
            do_op(op2, f, pick(sel8 ? 8 : 32), pick(sel8 ? 8 : 32), sel8 ? "rnd8" : "rnd32");
        end
        sel8 = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_muldiv();
        test_busy_ignore();
        test_reset_abort();
        test_width8();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

endmodule
